// File: rtl/pixel_raster_pkg.sv
// Shared widths and width-derivation helpers for the triangle raster pipe.
// Pure declarations: no latency, no flow control.
package pixel_raster_pkg;

    localparam int NUM_POLY_DEF = 4;
    localparam int X_W_DEF      = 7;
    localparam int Y_W_DEF      = 6;
    localparam int COLOR_W_DEF  = 6;
    localparam int DEPTH_W_DEF  = 3;

    // Signed differences are X_W+1 / Y_W+1 bits, so each product needs
    // X_W+Y_W+2 bits and their difference one more.
    function automatic int edge_w(input int xw, input int yw);
        return xw + yw + 3;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_edge_eval.sv
// One triangle's three signed edge functions, registered with its attributes.
// Latency 1 cycle; free-running, never stalls.
module pixel_edge_eval
    import pixel_raster_pkg::*;
#(
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int DEPTH_W = DEPTH_W_DEF,
    parameter int EW      = edge_w(X_W, Y_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [X_W-1:0]       pix_x,
    input  logic [Y_W-1:0]       pix_y,
    input  logic                 en,
    input  logic [X_W-1:0]       v0_x,
    input  logic [X_W-1:0]       v1_x,
    input  logic [X_W-1:0]       v2_x,
    input  logic [Y_W-1:0]       v0_y,
    input  logic [Y_W-1:0]       v1_y,
    input  logic [Y_W-1:0]       v2_y,
    input  logic [COLOR_W-1:0]   color,
    input  logic [DEPTH_W-1:0]   depth,
    output logic signed [EW-1:0] e0,
    output logic signed [EW-1:0] e1,
    output logic signed [EW-1:0] e2,
    output logic                 en_q,
    output logic [COLOR_W-1:0]   color_q,
    output logic [DEPTH_W-1:0]   depth_q
);

    function automatic logic signed [EW-1:0] edge_fn(
        input logic [X_W-1:0] px,
        input logic [Y_W-1:0] py,
        input logic [X_W-1:0] xa,
        input logic [Y_W-1:0] ya,
        input logic [X_W-1:0] xb,
        input logic [Y_W-1:0] yb
    );
        logic signed [X_W:0] dx_p;
        logic signed [X_W:0] dx_e;
        logic signed [Y_W:0] dy_p;
        logic signed [Y_W:0] dy_e;
        dx_p = $signed({1'b0, px} - {1'b0, xa});
        dx_e = $signed({1'b0, xb} - {1'b0, xa});
        dy_p = $signed({1'b0, py} - {1'b0, ya});
        dy_e = $signed({1'b0, yb} - {1'b0, ya});
        return EW'(dx_p) * EW'(dy_e) - EW'(dy_p) * EW'(dx_e);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            e0      <= '0;
            e1      <= '0;
            e2      <= '0;
            en_q    <= 1'b0;
            color_q <= '0;
            depth_q <= '0;
        end else begin
            e0      <= edge_fn(pix_x, pix_y, v0_x, v0_y, v1_x, v1_y);
            e1      <= edge_fn(pix_x, pix_y, v1_x, v1_y, v2_x, v2_y);
            e2      <= edge_fn(pix_x, pix_y, v2_x, v2_y, v0_x, v0_y);
            en_q    <= en;
            color_q <= color;
            depth_q <= depth;
        end
    end

endmodule

// File: rtl/pixel_raster_pipe.sv
// Rasterises NUM_POLY double-buffered triangles per pixel with depth resolve.
// Latency 3 cycles at 1 pixel/cycle; no backpressure, bubbles pass through.
module pixel_raster_pipe
    import pixel_raster_pkg::*;
#(
    parameter int NUM_POLY = NUM_POLY_DEF,
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int DEPTH_W  = DEPTH_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_load,
    input  logic [NUM_POLY-1:0]           poly_en,
    input  logic [NUM_POLY*X_W-1:0]       poly_v0_x,
    input  logic [NUM_POLY*X_W-1:0]       poly_v1_x,
    input  logic [NUM_POLY*X_W-1:0]       poly_v2_x,
    input  logic [NUM_POLY*Y_W-1:0]       poly_v0_y,
    input  logic [NUM_POLY*Y_W-1:0]       poly_v1_y,
    input  logic [NUM_POLY*Y_W-1:0]       poly_v2_y,
    input  logic [NUM_POLY*COLOR_W-1:0]   poly_color,
    input  logic [NUM_POLY*DEPTH_W-1:0]   poly_depth,
    input  logic [COLOR_W-1:0]            background_color,
    input  logic                          pix_valid,
    input  logic [X_W-1:0]                pix_x,
    input  logic [Y_W-1:0]                pix_y,
    output logic                          out_valid,
    output logic [COLOR_W-1:0]            pixel_out,
    output logic                          out_hit,
    output logic [idx_w(NUM_POLY)-1:0]    out_poly_idx
);

    localparam int EW    = edge_w(X_W, Y_W);
    localparam int IDX_W = idx_w(NUM_POLY);

    // Active polygon set: only frame_load updates it, so mid-frame writes to
    // the staged inputs cannot tear the image.
    logic [NUM_POLY-1:0]         act_en;
    logic [NUM_POLY*X_W-1:0]     act_v0_x, act_v1_x, act_v2_x;
    logic [NUM_POLY*Y_W-1:0]     act_v0_y, act_v1_y, act_v2_y;
    logic [NUM_POLY*COLOR_W-1:0] act_color;
    logic [NUM_POLY*DEPTH_W-1:0] act_depth;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_en    <= '0;
            act_v0_x  <= '0;
            act_v1_x  <= '0;
            act_v2_x  <= '0;
            act_v0_y  <= '0;
            act_v1_y  <= '0;
            act_v2_y  <= '0;
            act_color <= '0;
            act_depth <= '0;
        end else if (frame_load) begin
            act_en    <= poly_en;
            act_v0_x  <= poly_v0_x;
            act_v1_x  <= poly_v1_x;
            act_v2_x  <= poly_v2_x;
            act_v0_y  <= poly_v0_y;
            act_v1_y  <= poly_v1_y;
            act_v2_y  <= poly_v2_y;
            act_color <= poly_color;
            act_depth <= poly_depth;
        end
    end

    logic                 s1_valid;
    logic [COLOR_W-1:0]   s1_bg;
    logic signed [EW-1:0] s1_e0 [NUM_POLY];
    logic signed [EW-1:0] s1_e1 [NUM_POLY];
    logic signed [EW-1:0] s1_e2 [NUM_POLY];
    logic [NUM_POLY-1:0]  s1_en;
    logic [COLOR_W-1:0]   s1_color [NUM_POLY];
    logic [DEPTH_W-1:0]   s1_depth [NUM_POLY];
    logic [NUM_POLY-1:0]  s1_in;

    for (genvar g = 0; g < NUM_POLY; g++) begin : g_poly
        logic [2:0] neg, zero, pos;

        pixel_edge_eval #(
            .X_W     (X_W),
            .Y_W     (Y_W),
            .COLOR_W (COLOR_W),
            .DEPTH_W (DEPTH_W),
            .EW      (EW)
        ) u_edge (
            .clk     (clk),
            .rst     (rst),
            .pix_x   (pix_x),
            .pix_y   (pix_y),
            .en      (act_en[g]),
            .v0_x    (act_v0_x[g*X_W +: X_W]),
            .v1_x    (act_v1_x[g*X_W +: X_W]),
            .v2_x    (act_v2_x[g*X_W +: X_W]),
            .v0_y    (act_v0_y[g*Y_W +: Y_W]),
            .v1_y    (act_v1_y[g*Y_W +: Y_W]),
            .v2_y    (act_v2_y[g*Y_W +: Y_W]),
            .color   (act_color[g*COLOR_W +: COLOR_W]),
            .depth   (act_depth[g*DEPTH_W +: DEPTH_W]),
            .e0      (s1_e0[g]),
            .e1      (s1_e1[g]),
            .e2      (s1_e2[g]),
            .en_q    (s1_en[g]),
            .color_q (s1_color[g]),
            .depth_q (s1_depth[g])
        );

        assign neg  = {s1_e2[g][EW-1], s1_e1[g][EW-1], s1_e0[g][EW-1]};
        assign zero = {s1_e2[g] == '0, s1_e1[g] == '0, s1_e0[g] == '0};
        assign pos  = ~neg & ~zero;
        // Either winding counts; an all-zero triangle fails both terms.
        assign s1_in[g] = s1_en[g] & ((~|neg & |pos) | (~|pos & |neg));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_bg    <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_bg    <= background_color;
        end
    end

    logic                s2_valid;
    logic [COLOR_W-1:0]  s2_bg;
    logic [NUM_POLY-1:0] s2_in;
    logic [COLOR_W-1:0]  s2_color [NUM_POLY];
    logic [DEPTH_W-1:0]  s2_depth [NUM_POLY];

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_bg    <= '0;
            s2_in    <= '0;
            s2_color <= '{default: '0};
            s2_depth <= '{default: '0};
        end else begin
            s2_valid <= s1_valid;
            s2_bg    <= s1_bg;
            s2_in    <= s1_in;
            s2_color <= s1_color;
            s2_depth <= s1_depth;
        end
    end

    logic               win_hit;
    logic [IDX_W-1:0]   win_idx;
    logic [DEPTH_W-1:0] win_depth;
    logic [COLOR_W-1:0] win_color;

    // Strict less-than keeps the lowest index on a depth tie.
    always_comb begin
        win_hit   = 1'b0;
        win_idx   = '0;
        win_depth = '0;
        win_color = '0;
        for (int i = 0; i < NUM_POLY; i++) begin
            if (s2_in[i] && (!win_hit || s2_depth[i] < win_depth)) begin
                win_hit   = 1'b1;
                win_idx   = IDX_W'(i);
                win_depth = s2_depth[i];
                win_color = s2_color[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            pixel_out    <= '0;
            out_hit      <= 1'b0;
            out_poly_idx <= '0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                pixel_out    <= win_hit ? win_color : s2_bg;
                out_hit      <= win_hit;
                out_poly_idx <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_pixel_raster_pipe.sv
// Random + directed bench for pixel_raster_pipe against a queue-based reference model.
module tb_pixel_raster_pipe;

    localparam int NP = 4;
    localparam int XW = 7;
    localparam int YW = 6;
    localparam int CW = 6;
    localparam int DW = 3;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_load;
    logic [NP-1:0]     poly_en;
    logic [NP*XW-1:0]  poly_v0_x, poly_v1_x, poly_v2_x;
    logic [NP*YW-1:0]  poly_v0_y, poly_v1_y, poly_v2_y;
    logic [NP*CW-1:0]  poly_color;
    logic [NP*DW-1:0]  poly_depth;
    logic [CW-1:0]     background_color;
    logic              pix_valid;
    logic [XW-1:0]     pix_x;
    logic [YW-1:0]     pix_y;
    logic              out_valid;
    logic [CW-1:0]     pixel_out;
    logic              out_hit;
    logic [IW-1:0]     out_poly_idx;

    always #5 clk = ~clk;

    pixel_raster_pipe #(
        .NUM_POLY (NP), .X_W (XW), .Y_W (YW), .COLOR_W (CW), .DEPTH_W (DW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_load       (frame_load),
        .poly_en          (poly_en),
        .poly_v0_x        (poly_v0_x),
        .poly_v1_x        (poly_v1_x),
        .poly_v2_x        (poly_v2_x),
        .poly_v0_y        (poly_v0_y),
        .poly_v1_y        (poly_v1_y),
        .poly_v2_y        (poly_v2_y),
        .poly_color       (poly_color),
        .poly_depth       (poly_depth),
        .background_color (background_color),
        .pix_valid        (pix_valid),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .out_valid        (out_valid),
        .pixel_out        (pixel_out),
        .out_hit          (out_hit),
        .out_poly_idx     (out_poly_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_en  [NP];
    int m_x   [NP][3];
    int m_y   [NP][3];
    int m_col [NP];
    int m_dep [NP];

    typedef struct {
        int due;
        int col;
        int hit;
        int idx;
    } exp_t;

    exp_t q[$];
    int   ecnt      = 0;
    bit   model_rdy = 1'b0;
    int   last_col  = 0;
    int   last_hit  = 0;
    int   last_idx  = 0;
    int   vcount    = 0;

    function automatic void model_px(input int px, input int py, input int bg,
                                     output int col, output int hit, output int idx);
        int best;
        col  = bg;
        hit  = 0;
        idx  = 0;
        best = 1 << 30;
        for (int i = 0; i < NP; i++) begin
            int  e;
            bit  any_pos, any_neg;
            any_pos = 0;
            any_neg = 0;
            for (int k = 0; k < 3; k++) begin
                int b;
                b = (k + 1) % 3;
                e = (px - m_x[i][k]) * (m_y[i][b] - m_y[i][k])
                  - (py - m_y[i][k]) * (m_x[i][b] - m_x[i][k]);
                if (e > 0) any_pos = 1;
                if (e < 0) any_neg = 1;
            end
            // Inside iff the edge signs never disagree and are not all zero.
            if (m_en[i] != 0 && (any_pos != any_neg) && m_dep[i] < best) begin
                best = m_dep[i];
                hit  = 1;
                idx  = i;
                col  = m_col[i];
            end
        end
    endfunction

    always @(posedge clk) begin
        ecnt++;
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                m_en[i] = 0; m_col[i] = 0; m_dep[i] = 0;
                for (int k = 0; k < 3; k++) begin m_x[i][k] = 0; m_y[i][k] = 0; end
            end
            q.delete();
            last_col  = 0;
            last_hit  = 0;
            last_idx  = 0;
            model_rdy = 1'b1;
        end else begin
            if (pix_valid) begin
                exp_t e;
                model_px(int'(pix_x), int'(pix_y), int'(background_color), e.col, e.hit, e.idx);
                e.due = ecnt + 2;
                q.push_back(e);
            end
            if (frame_load) begin
                for (int i = 0; i < NP; i++) begin
                    m_en[i]   = int'(poly_en[i]);
                    m_x[i][0] = int'(poly_v0_x[i*XW +: XW]);
                    m_x[i][1] = int'(poly_v1_x[i*XW +: XW]);
                    m_x[i][2] = int'(poly_v2_x[i*XW +: XW]);
                    m_y[i][0] = int'(poly_v0_y[i*YW +: YW]);
                    m_y[i][1] = int'(poly_v1_y[i*YW +: YW]);
                    m_y[i][2] = int'(poly_v2_y[i*YW +: YW]);
                    m_col[i]  = int'(poly_color[i*CW +: CW]);
                    m_dep[i]  = int'(poly_depth[i*DW +: DW]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_rdy) begin
            bit want;
            want = (q.size() > 0) && (q[0].due == ecnt);
            if (want) begin
                exp_t e;
                e = q.pop_front();
                last_col = e.col;
                last_hit = e.hit;
                last_idx = e.idx;
            end
            chk("cmp.out_valid", 32'(out_valid), 32'(want));
            chk("cmp.pixel_out", 32'(pixel_out), last_col);
            chk("cmp.out_hit", 32'(out_hit), last_hit);
            chk("cmp.out_poly_idx", 32'(out_poly_idx), last_idx);
        end
        if (out_valid === 1'b1) vcount++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_poly(input int i, input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2, input int col, input int dep, input int en);
        poly_v0_x[i*XW +: XW]  = XW'(x0);
        poly_v0_y[i*YW +: YW]  = YW'(y0);
        poly_v1_x[i*XW +: XW]  = XW'(x1);
        poly_v1_y[i*YW +: YW]  = YW'(y1);
        poly_v2_x[i*XW +: XW]  = XW'(x2);
        poly_v2_y[i*YW +: YW]  = YW'(y2);
        poly_color[i*CW +: CW] = CW'(col);
        poly_depth[i*DW +: DW] = DW'(dep);
        poly_en[i]             = (en != 0);
    endtask

    task automatic load();
        frame_load = 1'b1;
        @(negedge clk);
        frame_load = 1'b0;
    endtask

    task automatic lit_px(input string nm, input int x, input int y, input int bg,
                          input int ecol, input int ehit, input int eidx);
        pix_valid        = 1'b1;
        pix_x            = XW'(x);
        pix_y            = YW'(y);
        background_color = CW'(bg);
        @(negedge clk);
        pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk({nm, ".valid"}, 32'(out_valid), 1);
        chk({nm, ".pixel"}, 32'(pixel_out), ecol);
        chk({nm, ".hit"}, 32'(out_hit), ehit);
        chk({nm, ".idx"}, 32'(out_poly_idx), eidx);
    endtask

    task automatic rand_poly(input int i);
        set_poly(i, int'($urandom_range(127)), int'($urandom_range(63)),
                    int'($urandom_range(127)), int'($urandom_range(63)),
                    int'($urandom_range(127)), int'($urandom_range(63)),
                    int'($urandom_range(63)), int'($urandom_range(7)),
                    ($urandom_range(4) != 0) ? 1 : 0);
    endtask

    initial begin
        int c0;
        rst = 1'b1; frame_load = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
        background_color = '0; poly_en = '0;
        poly_v0_x = '0; poly_v1_x = '0; poly_v2_x = '0;
        poly_v0_y = '0; poly_v1_y = '0; poly_v2_y = '0;
        poly_color = '0; poly_depth = '0;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.pixel_out", 32'(pixel_out), 0);
        chk("rst.idx", 32'(out_poly_idx), 0);
        rst = 1'b0;

        lit_px("t1", 5, 5, 'h15, 'h15, 0, 0);

        set_poly(0, 10, 10, 40, 10, 10, 40, 'h30, 2, 1);
        load();
        lit_px("t2.in", 15, 15, 'h15, 'h30, 1, 0);
        lit_px("t2.vtx", 10, 10, 'h15, 'h30, 1, 0);
        lit_px("t2.out", 40, 40, 'h15, 'h15, 0, 0);
        set_poly(0, 10, 10, 10, 40, 40, 10, 'h30, 2, 1);
        load();
        lit_px("t2s.in", 15, 15, 'h15, 'h30, 1, 0);
        lit_px("t2s.vtx", 10, 10, 'h15, 'h30, 1, 0);
        lit_px("t2s.out", 40, 40, 'h15, 'h15, 0, 0);

        set_poly(0, 10, 10, 40, 10, 10, 40, 'h03, 5, 1);
        set_poly(1, 10, 10, 40, 10, 10, 40, 'h0C, 1, 1);
        load();
        lit_px("t3.near", 15, 15, 'h15, 'h0C, 1, 1);
        set_poly(0, 10, 10, 40, 10, 10, 40, 'h03, 4, 1);
        set_poly(1, 10, 10, 40, 10, 10, 40, 'h0C, 4, 1);
        load();
        lit_px("t3.tie", 15, 15, 'h15, 'h03, 1, 0);

        set_poly(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_poly(0, 0, 0, 20, 20, 40, 40, 'h30, 2, 1);
        load();
        lit_px("t4.degen", 10, 10, 'h15, 'h15, 0, 0);

        set_poly(0, 10, 10, 40, 10, 10, 40, 'h30, 2, 1);
        load();
        pix_valid = 1'b1; pix_x = 7'd15; pix_y = 6'd15; background_color = 6'h15;
        repeat (4) @(negedge clk);
        set_poly(0, 10, 10, 40, 10, 10, 40, 'h3F, 2, 1);
        repeat (4) @(negedge clk);
        chk("t5.staged", 32'(pixel_out), 'h30);
        frame_load = 1'b1;
        @(negedge clk);
        frame_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5.pix_k", 32'(pixel_out), 'h30);
        @(negedge clk);
        chk("t5.pix_k1", 32'(pixel_out), 'h3F);
        pix_valid = 1'b0;
        repeat (4) @(negedge clk);

        c0 = vcount;
        for (int i = 0; i < 64; i++) begin
            pix_valid = 1'b1;
            pix_x = XW'($urandom); pix_y = YW'($urandom); background_color = CW'($urandom);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6.count", vcount - c0, 64);

        for (int i = 0; i < 10; i++) begin
            pix_valid = 1'b1;
            pix_x = XW'($urandom); pix_y = YW'($urandom);
            @(negedge clk);
        end
        rst = 1'b1; pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        c0 = vcount;
        repeat (4) @(negedge clk);
        chk("t6.rst_drop", vcount - c0, 0);

        for (int i = 0; i < NP; i++) rand_poly(i);
        load();
        for (int n = 0; n < 3000; n++) begin
            pix_valid = ($urandom_range(3) != 0);
            pix_x = XW'($urandom); pix_y = YW'($urandom); background_color = CW'($urandom);
            if ($urandom_range(15) == 0) rand_poly(int'($urandom_range(NP - 1)));
            frame_load = ($urandom_range(19) == 0);
            rst = ($urandom_range(199) == 0);
            @(negedge clk);
        end
        rst = 1'b0; frame_load = 1'b0; pix_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
